// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  localparam int unsigned DIV_ITER  = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_divcore.sv
// Iterative restoring divider: one quotient bit per cycle on unsigned magnitudes,
// signs reapplied on the final step. Special cases are resolved by the caller.
module muldiv_divcore
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            op_signed,
  input  logic            op_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            last,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(DIV_ITER);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            rem_sel_q, rem_sel_d;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic            a_neg;
  logic            b_neg;

  // quo_q doubles as the dividend shift register: its MSB feeds the remainder
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvsr_q};
    if (diff[XLEN]) begin
      rem_step = shifted[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_step = diff[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b1};
    end
    quo_fix = neg_quo_q ? -quo_step : quo_step;
    rem_fix = neg_rem_q ? -rem_step : rem_step;
    result  = rem_sel_q ? rem_fix : quo_fix;
    last    = (cnt_q == CW'(DIV_ITER - 1));
  end

  always_comb begin
    cnt_d     = cnt_q;
    dvsr_d    = dvsr_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_sel_d = rem_sel_q;
    a_neg     = op_signed & dividend[XLEN-1];
    b_neg     = op_signed & divisor[XLEN-1];
    if (load) begin
      cnt_d     = '0;
      rem_d     = '0;
      quo_d     = a_neg ? -dividend : dividend;
      dvsr_d    = b_neg ? -divisor : divisor;
      neg_quo_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      rem_sel_d = op_rem;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      rem_d = rem_step;
      quo_d = quo_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      dvsr_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dvsr_q    <= dvsr_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_sel_q <= rem_sel_d;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M unit: single-cycle multiply, 32-step divide.
// Divide support is built only when MULDIV_DIV_EN is defined; otherwise divide ops return 0.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            md_req,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  md_state_e       state_q, state_d;
  logic            md_done_q, md_done_d;
  logic [XLEN-1:0] md_result_q, md_result_d;

  md_op_e            op;
  logic              sgn_a;
  logic              sgn_b;
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    op      = md_op_e'(funct3);
    sgn_a   = (op == OP_MULH) || (op == OP_MULHSU);
    sgn_b   = (op == OP_MULH);
    a_ext   = {{XLEN{sgn_a & op_a[XLEN-1]}}, op_a};
    b_ext   = {{XLEN{sgn_b & op_b[XLEN-1]}}, op_b};
    product = a_ext * b_ext;
    mul_res = (op == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_DIV_EN
  logic            div_signed;
  logic            div_rem;
  logic            div_load;
  logic            div_step;
  logic            div_last;
  logic [XLEN-1:0] div_result;

  assign div_signed = (op == OP_DIV) || (op == OP_REM);
  assign div_rem    = (op == OP_REM) || (op == OP_REMU);

  muldiv_divcore #(
    .XLEN(XLEN)
  ) u_divcore (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .step     (div_step),
    .op_signed(div_signed),
    .op_rem   (div_rem),
    .dividend (op_a),
    .divisor  (op_b),
    .last     (div_last),
    .result   (div_result)
  );
`endif

  always_comb begin
    state_d     = state_q;
    md_done_d   = 1'b0;
    md_result_d = md_result_q;
`ifdef MULDIV_DIV_EN
    div_load    = 1'b0;
    div_step    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (md_req) begin
          state_d   = S_DONE;
          md_done_d = 1'b1;
          if (!funct3[2]) begin
            md_result_d = mul_res;
          end else begin
`ifdef MULDIV_DIV_EN
            if (op_b == '0) begin
              md_result_d = funct3[1] ? op_a : DIV0_QUOT;
            end else if (div_signed && (op_a == INT_MIN) && (op_b == '1)) begin
              md_result_d = funct3[1] ? '0 : INT_MIN;
            end else begin
              div_load  = 1'b1;
              state_d   = S_DIV;
              md_done_d = 1'b0;
            end
`else
            md_result_d = '0;
`endif
          end
        end
      end
`ifdef MULDIV_DIV_EN
      S_DIV: begin
        div_step = 1'b1;
        if (div_last) begin
          md_result_d = div_result;
          state_d     = S_DONE;
          md_done_d   = 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flush overrides everything above, including an accept in the same cycle
    if (flush) begin
      state_d     = S_IDLE;
      md_done_d   = 1'b0;
      md_result_d = md_result_q;
`ifdef MULDIV_DIV_EN
      div_load    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      md_done_q   <= 1'b0;
      md_result_q <= '0;
    end else begin
      state_q     <= state_d;
      md_done_q   <= md_done_d;
      md_result_q <= md_result_d;
    end
  end

  assign md_stall  = md_req & (state_q != S_DONE);
  assign md_done   = md_done_q;
  assign md_result = md_result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised self-checking bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        md_req = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        md_stall;
  logic        md_done;
  logic [31:0] md_result;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_res = '0;
  logic        prev_stall = 1'b0;

  always #5 clk = ~clk;

  ex_muldiv #(
    .XLEN(32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_req   (md_req),
    .flush    (flush),
    .funct3   (funct3),
    .op_a     (op_a),
    .op_b     (op_b),
    .md_stall (md_stall),
    .md_done  (md_done),
    .md_result(md_result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // md_req must not drop while an unflushed op is stalling the front end
  always @(posedge clk) begin
    if (rst_n && prev_stall) check("req_hold", 32'(md_req), 32'd1);
    prev_stall <= md_stall & ~flush & rst_n;
  end

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      pa, pb, p;
    logic [63:0] pu;
    int          sa, sb;
    sa = a;
    sb = b;
    pa = (f == 3'b001 || f == 3'b010) ? longint'($signed(a)) : longint'({32'b0, a});
    pb = (f == 3'b001) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = pa * pb;
    pu = p;
    if (f[2] && !DIV_ON) return 32'd0;
    case (f)
      3'b000: return pu[31:0];
      3'b001, 3'b010, 3'b011: return pu[63:32];
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!DIV_ON || !f[2] || b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Drive an op in the current cycle (T); stall must already be visible
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    md_req = 1'b1;
    flush  = 1'b0;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    #1;
    check("stall_T", 32'(md_stall), 32'd1);
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat);
    int k;
    int stalls;
    k = 0;
    stalls = 1;
    while (k < 60) begin
      @(posedge clk);
      #1;
      k++;
      if (md_done) break;
      if (md_stall) stalls++;
    end
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_res"}, md_result, exp_res);
    check({tag, "_stalls"}, 32'(stalls), 32'(exp_lat));
    check({tag, "_stall_done"}, 32'(md_stall), 32'd0);
    last_res = exp_res;
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(md_done), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res);
    @(negedge clk);
    issue(f, a, b);
    wait_done(tag, exp_res, ref_lat(f, a, b));
  endtask

  task automatic idle(input int n);
    md_req = 1'b0;
    flush  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(md_done), 32'd0);
    check("rst_res", md_result, 32'd0);
    check("rst_stall", 32'(md_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, DIV_ON ? 32'hFFFF_FFFD : 32'd0);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, DIV_ON ? 32'hFFFF_FFFF : 32'd0);
    run_op("divu0", 3'b101, 32'd12345, 32'd0, DIV_ON ? 32'hFFFF_FFFF : 32'd0);
    run_op("remu0", 3'b111, 32'd17, 32'd0, DIV_ON ? 32'd17 : 32'd0);
    run_op("mul_nz", 3'b000, 32'd6, 32'd7, 32'd42);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, DIV_ON ? 32'h8000_0000 : 32'd0);
    run_op("div10_2", 3'b100, 32'd10, 32'd2, DIV_ON ? 32'd5 : 32'd0);
    idle(1);

    // Flush in the accept cycle: nothing is accepted, unit stays idle
    @(negedge clk);
    md_req = 1'b1;
    flush  = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'd3;
    op_b   = 32'd3;
    @(posedge clk);
    #1;
    check("flushT_done", 32'(md_done), 32'd0);
    check("flushT_res", md_result, last_res);
    issue(3'b000, 32'd3, 32'd3);
    wait_done("after_flushT", 32'd9, 1);
    idle(1);

`ifdef MULDIV_DIV_EN
    @(negedge clk);
    issue(3'b100, 32'd1000, 32'd3);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_div_done", 32'(md_done), 32'd0);
    check("flush_div_res", md_result, last_res);
    issue(3'b101, 32'd100, 32'd7);
    wait_done("divu_after_flush", 32'd14, 33);
    idle(1);

    @(negedge clk);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
`else
    @(negedge clk);
    issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    @(posedge clk);
    #1;
    check("pre_rst_done", 32'(md_done), 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    check("midrst_done", 32'(md_done), 32'd0);
    check("midrst_res", md_result, 32'd0);
    md_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    idle(1);

    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op("rand", f, a, b, ref_res(f, a, b));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
